// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU pipeline control logic:
// register-address constants, hazard FSM encoding and the pipeline control bundle.
package cpu_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hcu_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_sel_branch;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_write;
  } pipe_ctrl_t;

  // Canonical control patterns, in pipe_ctrl_t field order.
  localparam pipe_ctrl_t CTRL_DEFAULT = 8'b1010_1011;
  localparam pipe_ctrl_t CTRL_HOLD    = 8'b0000_0000;
  localparam pipe_ctrl_t CTRL_BRANCH  = 8'b1111_1111;
  localparam pipe_ctrl_t CTRL_BUBBLE  = 8'b0000_1111;

  // A load in EX whose destination feeds the ID instruction cannot be forwarded in time.
  function automatic logic load_use_hazard(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  uses_rs1,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic                  uses_rs2,
    input logic [REG_ADDR_W-1:0] rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: memory freeze, branch flush and load-use bubble
// generation, with a sticky memory-timeout state and saturating perf counters.
module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd64,
  parameter int         CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs1,
  input  logic                  ifid_uses_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  branch_taken,
  input  logic                  exmem_mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_sel_branch,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  memwb_write,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  hcu_state_e state_d, state_q;
  logic [7:0] wait_cnt_d, wait_cnt_q;
  pipe_ctrl_t ctrl;
  logic       freeze;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_DEFAULT;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    freeze   = (state_q != MEM_ERR) && exmem_mem_req && !mem_ready;
    load_use = load_use_hazard(idex_mem_read, idex_rd, ifid_uses_rs1, ifid_rs1,
                               ifid_uses_rs2, ifid_rs2);

    // Freeze outranks branch: EX is held, so the branch is presented again afterwards.
    if (state_q == MEM_ERR || freeze) begin
      ctrl      = CTRL_HOLD;
      stall_inc = 1'b1;
    end else if (branch_taken) begin
      ctrl      = CTRL_BRANCH;
      flush_inc = 1'b1;
    end else if (load_use) begin
      ctrl      = CTRL_BUBBLE;
      stall_inc = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == MEM_TIMEOUT - 8'd1) begin
          state_d = MEM_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MEM_ERR: state_d = MEM_ERR;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign ifid_write    = ctrl.ifid_write;
  assign ifid_flush    = ctrl.ifid_flush;
  assign idex_write    = ctrl.idex_write;
  assign idex_flush    = ctrl.idex_flush;
  assign exmem_write   = ctrl.exmem_write;
  assign memwb_write   = ctrl.memwb_write;
  assign mem_error     = (state_q == MEM_ERR);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit with a short timeout and narrow counters.
module tb_hazard_control_unit;

  localparam logic [7:0] TO   = 8'd4;
  localparam int         CW   = 4;
  localparam int         CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic ifid_uses_rs1 = 0, ifid_uses_rs2 = 0, idex_mem_read = 0;
  logic branch_taken = 0, exmem_mem_req = 0, mem_ready = 0;
  logic pc_write, pc_sel_branch, ifid_write, ifid_flush;
  logic idex_write, idex_flush, exmem_write, memwb_write, mem_error;
  logic [CW-1:0] stall_count, flush_count;

  hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .exmem_mem_req(exmem_mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    ctrl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = timed out.
  int m_state = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, push the model's expectation, compare at negedge, advance model.
  task automatic step(input string tag, input logic br, input logic req, input logic rdy,
                      input logic mr, input logic [3:0] rd, input logic u1, input logic [3:0] rs1,
                      input logic u2, input logic [3:0] rs2);
    exp_t e, o;
    logic frz, lu;
    @(posedge clk);
    #1;
    branch_taken = br; exmem_mem_req = req; mem_ready = rdy;
    idex_mem_read = mr; idex_rd = rd;
    ifid_uses_rs1 = u1; ifid_rs1 = rs1; ifid_uses_rs2 = u2; ifid_rs2 = rs2;

    frz = (m_state != 2) && req && !rdy;
    lu  = mr && (rd != 4'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.err   = (m_state == 2);
    e.stall = m_stall[CW-1:0];
    e.flush = m_flush[CW-1:0];
    if (m_state == 2 || frz) begin
      e.ctrl = 8'h00;
      if (m_stall < CMAX) m_stall++;
    end else if (br) begin
      e.ctrl = 8'hFF;
      if (m_flush < CMAX) m_flush++;
    end else if (lu) begin
      e.ctrl = 8'h0F;
      if (m_stall < CMAX) m_stall++;
    end else begin
      e.ctrl = 8'hAB;
    end
    sb.push_back(e);

    if (m_state == 0 && frz) begin
      m_state = 1; m_wait = 0;
    end else if (m_state == 1) begin
      if (!frz) begin
        m_state = 0; m_wait = 0;
      end else if (m_wait == int'(TO) - 1) begin
        m_state = 2;
      end else begin
        m_wait++;
      end
    end

    @(negedge clk);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      o = sb.pop_front();
      check_vec({tag, ".ctrl"}, {pc_write, pc_sel_branch, ifid_write, ifid_flush,
                                 idex_write, idex_flush, exmem_write, memwb_write}, o.ctrl);
      check_bit({tag, ".mem_error"}, mem_error, o.err);
      check_vec({tag, ".stall_count"}, 8'(stall_count), 8'(o.stall));
      check_vec({tag, ".flush_count"}, 8'(flush_count), 8'(o.flush));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    branch_taken = 0; exmem_mem_req = 0; mem_ready = 0; idex_mem_read = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
  endtask

  initial begin
    do_reset();
    idle("reset_idle");

    // Load-use via rs2, then via rs1; R0 and unused operands never stall.
    step("lu_rs2", 0, 0, 0, 1, 4'd3, 0, 4'd0, 1, 4'd3);
    idle("after_lu");
    step("lu_r0", 0, 0, 0, 1, 4'd0, 0, 4'd0, 1, 4'd0);
    step("lu_unused", 0, 0, 0, 1, 4'd5, 0, 4'd5, 0, 4'd5);
    step("lu_noload", 0, 0, 0, 0, 4'd5, 1, 4'd5, 0, 4'd0);
    step("lu_rs1", 0, 0, 0, 1, 4'd7, 1, 4'd7, 0, 4'd0);
    step("branch_vs_lu", 1, 0, 0, 1, 4'd3, 0, 4'd0, 1, 4'd3);
    idle("after_branch");

    // Memory wait: three not-ready cycles (branch ignored mid-wait), then ready.
    do_reset();
    step("memwait0", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("memwait1", 1, 1, 0, 1, 4'd2, 1, 4'd2, 0, 4'd0);
    step("memwait2", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("memready", 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("branch_replay", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    idle("after_memwait");

    // Timeout: never ready, sticky error even once ready appears; reset recovers.
    do_reset();
    for (int i = 0; i < 7; i++) step("timeout", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("err_sticky", 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("err_idle", 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    do_reset();
    idle("post_err_reset");

    // Reset in the middle of a memory wait.
    step("wait_pre_rst", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    step("wait_pre_rst2", 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    do_reset();
    idle("post_wait_reset");

    // Saturation of both counters.
    for (int i = 0; i < 20; i++) step("stall_sat", 0, 0, 0, 1, 4'd9, 1, 4'd9, 0, 4'd0);
    for (int i = 0; i < 20; i++) step("flush_sat", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
    idle("sat_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
